// File: rtl/board_uart_dumper.sv
// Streams the whole double_buffer board out over 8N1 UART as one frame:
// header 0xA5, every word's bytes LSB first, then the XOR of all payload bytes.
module board_uart_dumper #(
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned NUM_WORDS    = 4096,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              start_in,
    input  logic [DATA_W-1:0] data_r_in,
    output logic [ADDR_W-1:0] addr_r_out,
    output logic              tx_out,
    output logic              busy_out,
    output logic              done_out
);
    localparam int unsigned BYTES  = DATA_W / 8;
    localparam int unsigned BSEL_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned TMR_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [7:0]        HEADER    = 8'hA5;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    localparam logic [TMR_W-1:0]  TMR_MAX   = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [BSEL_W-1:0] LAST_BSEL = BSEL_W'(BYTES - 1);

    typedef enum logic [2:0] {IDLE, HDR, FETCH, LATCH, SEND, CSUM, FIN} state_t;
    state_t state, state_nxt;

    logic [DATA_W-1:0] word;
    logic [BSEL_W-1:0] bsel;
    logic [7:0]        checksum;
    logic [9:0]        shreg;
    logic [3:0]        bit_idx;
    logic [TMR_W-1:0]  timer;
    logic              active;

    logic       tx_last, tx_free;
    logic       load, payload, latch_word, next_byte, next_word, finish;
    logic [7:0] load_byte, cur_byte;

    // A byte may be queued in the same cycle the previous stop bit expires,
    // so back-to-back bytes leave no idle gap.
    assign tx_last  = active && (timer == '0) && (bit_idx == 4'd9);
    assign tx_free  = !active || tx_last;
    assign cur_byte = word[{bsel, 3'b000} +: 8];

    assign tx_out     = active ? shreg[0] : 1'b1;
    assign busy_out   = (state != IDLE);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        load_byte  = HEADER;
        payload    = 1'b0;
        latch_word = 1'b0;
        next_byte  = 1'b0;
        next_word  = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: if (start_in && !done_out) begin
                load      = 1'b1;
                state_nxt = HDR;
            end
            HDR:   state_nxt = FETCH;
            FETCH: state_nxt = LATCH;
            LATCH: begin
                latch_word = 1'b1;
                state_nxt  = SEND;
            end
            SEND: if (tx_free) begin
                load      = 1'b1;
                load_byte = cur_byte;
                payload   = 1'b1;
                if (bsel == LAST_BSEL) begin
                    if (addr_r_out == LAST_ADDR) begin
                        state_nxt = CSUM;
                    end else begin
                        next_word = 1'b1;
                        state_nxt = FETCH;
                    end
                end else begin
                    next_byte = 1'b1;
                end
            end
            CSUM: if (tx_free) begin
                load      = 1'b1;
                load_byte = checksum;
                state_nxt = FIN;
            end
            FIN: if (tx_last) begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            addr_r_out <= '0;
            word       <= '0;
            bsel       <= '0;
            checksum   <= '0;
            shreg      <= '1;
            bit_idx    <= '0;
            timer      <= '0;
            active     <= 1'b0;
            done_out   <= 1'b0;
        end else begin
            done_out <= finish;
            if (latch_word) begin
                word <= data_r_in;
                bsel <= '0;
            end
            if (next_byte) bsel <= bsel + 1'b1;
            if (next_word) addr_r_out <= addr_r_out + 1'b1;
            if (payload)   checksum <= checksum ^ cur_byte;
            if (finish) begin
                checksum   <= '0;
                addr_r_out <= '0;
            end

            if (load) begin
                shreg   <= {1'b1, load_byte, 1'b0};
                bit_idx <= '0;
                timer   <= TMR_MAX;
                active  <= 1'b1;
            end else if (active) begin
                if (timer == '0) begin
                    if (bit_idx == 4'd9) begin
                        active <= 1'b0;
                    end else begin
                        shreg   <= {1'b1, shreg[9:1]};
                        bit_idx <= bit_idx + 4'd1;
                        timer   <= TMR_MAX;
                    end
                end else begin
                    timer <= timer - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_board_uart_dumper.sv
// Bench for board_uart_dumper: a frame model built from memory contents is
// compared against tx_out sample by sample, with random and fixed boards.
module tb_board_uart_dumper;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [15:0] mem [2];
    logic [15:0] rd0, rd1;
    logic [11:0] addr0, addr1;
    logic        tx0, tx1, busy0, busy1, done0, done1;
    int          checks = 0, errors = 0;
    int          cyc = 0, ndone0 = 0, ndone1 = 0;
    logic [7:0]  exp_q [$];

    always #5 clk = ~clk;

    board_uart_dumper #(.ADDR_W(12), .DATA_W(16), .NUM_WORDS(2), .CLKS_PER_BIT(CPB)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start0), .data_r_in(rd0),
        .addr_r_out(addr0), .tx_out(tx0), .busy_out(busy0), .done_out(done0));

    board_uart_dumper #(.ADDR_W(12), .DATA_W(16), .NUM_WORDS(1), .CLKS_PER_BIT(CPB)) dut1 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start1), .data_r_in(rd1),
        .addr_r_out(addr1), .tx_out(tx1), .busy_out(busy1), .done_out(done1));

    // 1-cycle-latency BRAM read ports
    always @(posedge clk) begin
        rd0 <= mem[addr0[0]];
        rd1 <= mem[addr1[0]];
        cyc <= cyc + 1;
        if (done0) ndone0 <= ndone0 + 1;
        if (done1) ndone1 <= ndone1 + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("addr0_range", addr0 < 12'd2, 1);
            check("addr1_zero", addr1, 0);
        end
    end

    function automatic logic tx_s(input int sel);   return sel != 0 ? tx1 : tx0;     endfunction
    function automatic logic busy_s(input int sel); return sel != 0 ? busy1 : busy0; endfunction
    function automatic logic done_s(input int sel); return sel != 0 ? done1 : done0; endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel != 0) start1 = v; else start0 = v;
    endtask

    task automatic build(input int nw);
        logic [7:0] cs, b;
        logic [15:0] w;
        cs = 8'h00;
        exp_q = {};
        exp_q.push_back(8'hA5);
        for (int i = 0; i < nw; i++) begin
            w = mem[i];
            for (int k = 0; k < 2; k++) begin
                b = 8'(w >> (8 * k));
                exp_q.push_back(b);
                cs ^= b;
            end
        end
        exp_q.push_back(cs);
    endtask

    task automatic run_frame(input int sel, input int nw, input int abort_at, input bit poke);
        int n, gap, allow, d0, t0;
        logic [9:0] bits;
        build(nw);
        n = exp_q.size();
        check("pre_tx", tx_s(sel), 1);
        check("pre_busy", busy_s(sel), 0);
        d0 = (sel != 0) ? ndone1 : ndone0;
        t0 = cyc;
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        for (int k = 0; k < n; k++) begin
            bits = {1'b1, exp_q[k], 1'b0};
            for (int j = 0; j < 10; j++) begin
                for (int s = 0; s < CPB; s++) begin
                    if (k == abort_at && j == 4 && s == 0) begin
                        rst_n = 1'b0;
                        #1;
                        check("rst_tx", tx_s(sel), 1);
                        check("rst_busy", busy_s(sel), 0);
                        check("rst_done", done_s(sel), 0);
                        return;
                    end
                    set_start(sel, poke && k == 2 && j == 3 && s == 0);
                    check($sformatf("tx_b%0d_bit%0d", k, j), tx_s(sel), bits[j]);
                    check("busy_frame", busy_s(sel), 1);
                    @(negedge clk);
                end
            end
            if (k + 1 < n) begin
                // second byte of a word follows without a gap; others may idle up to 3
                allow = (k + 1 <= n - 2 && (k % 2) == 1) ? 0 : 3;
                gap = 0;
                while (tx_s(sel) == 1'b1 && gap <= allow) begin
                    check("busy_gap", busy_s(sel), 1);
                    gap++;
                    @(negedge clk);
                end
                check($sformatf("gap_ok_b%0d", k + 1), gap <= allow, 1);
                if (gap > allow) return;
            end
        end
        gap = 0;
        while (done_s(sel) != 1'b1 && gap < 8) begin
            check("tx_before_done", tx_s(sel), 1);
            gap++;
            @(negedge clk);
        end
        check("done_seen", done_s(sel), 1);
        check("done_latency", (cyc - t0) <= 252, 1);
        check("busy_at_done", busy_s(sel), 0);
        if (poke) set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        repeat (6) begin
            check("post_tx", tx_s(sel), 1);
            check("post_busy", busy_s(sel), 0);
            @(negedge clk);
        end
        check("done_count", ((sel != 0) ? ndone1 : ndone0) - d0, 1);
    endtask

    initial begin
        mem[0] = 16'h1234;
        mem[1] = 16'hABCD;
        @(negedge clk);
        check("reset_tx", tx0, 1);
        check("reset_busy", busy0, 0);
        check("reset_done", done0, 0);
        check("reset_addr", addr0, 0);
        check("reset_tx1", tx1, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        build(2);
        check("model_hdr", exp_q[0], 8'hA5);
        check("model_lsb", exp_q[1], 8'h34);
        check("model_b4", exp_q[4], 8'hAB);
        check("model_cs", exp_q[5], 8'h40);
        build(1);
        check("model_cs1", exp_q[3], 8'h26);

        run_frame(0, 2, -1, 1'b1);
        run_frame(0, 2, -1, 1'b0);

        repeat (3) @(negedge clk);
        run_frame(0, 2, 3, 1'b0);
        repeat (2) @(negedge clk);
        check("held_tx", tx0, 1);
        check("held_busy", busy0, 0);
        check("held_addr", addr0, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("no_resume", busy0, 0);
        run_frame(0, 2, -1, 1'b0);

        mem[0] = 16'h0000; mem[1] = 16'h0000;
        run_frame(0, 2, -1, 1'b0);
        mem[0] = 16'hFFFF; mem[1] = 16'hFFFF;
        build(2);
        check("model_ff_cs", exp_q[5], 8'h00);
        run_frame(0, 2, -1, 1'b0);

        mem[0] = 16'h1234; mem[1] = 16'hABCD;
        run_frame(1, 1, -1, 1'b1);

        for (int r = 0; r < 6; r++) begin
            mem[0] = 16'($urandom);
            mem[1] = 16'($urandom);
            run_frame(r % 2, 2 - (r % 2), -1, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running required finished");
        $fatal(1, "timeout");
    end

endmodule
